// File: rtl/hht_pkg.sv
// Shared definitions for the HHT memory responder: miss sentinel, region
// select encoding and the address-window check used by reads and writes.
package hht_pkg;

  localparam logic [31:0] SENTINEL = 32'd99999;

  typedef enum logic {
    REG_COL = 1'b0,
    REG_V   = 1'b1
  } region_e;

  typedef struct packed {
    logic        hit;
    logic [31:0] index;
  } win_t;

  // Upper bound is formed in 33 bits so a window near the top of the address
  // space never wraps around to cover low addresses.
  function automatic win_t win_check(input logic [31:0] base,
                                     input logic [32:0] limit,
                                     input logic [31:0] addr);
    win_t        w;
    logic [32:0] end_addr;
    end_addr = {1'b0, base} + limit;
    w.index  = addr - base;
    w.hit    = (addr >= base) && ({1'b0, addr} < end_addr);
    return w;
  endfunction

endpackage

// File: rtl/hht_rd_port.sv
// One read port of the responder: register-file storage with per-entry
// written bits, window check at request time and an RD_LAT-deep response pipe.
module hht_rd_port
  import hht_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter int          RD_LAT    = 2,
  parameter logic [31:0] MISS_DATA = SENTINEL,
  localparam int         IW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   base,
  input  logic [32:0]   limit,
  input  logic          rd_en,
  input  logic [31:0]   addr,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          rvalid,
  output logic          miss
);

  logic [31:0]       mem [DEPTH];
  logic [DEPTH-1:0]  written;

  win_t              rd_win;
  logic              unused_idx;
  logic              req_v_q;
  logic              req_hit_q;
  logic [IW-1:0]     req_idx_q;
  logic [31:0]       look_data;
  logic              look_miss;

  logic [RD_LAT-1:0] v_q;
  logic [RD_LAT-1:0] m_q;
  logic [31:0]       d_q [RD_LAT];

  assign rd_win     = win_check(base, limit, addr);
  assign unused_idx = ^rd_win.index[31:IW];

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[widx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written <= '0;
    end else if (we) begin
      written[widx] <= 1'b1;
    end
  end

  // The window is resolved when the request is sampled; the array is read one
  // cycle later, so a write sampled on the same edge is already visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_v_q   <= 1'b0;
      req_hit_q <= 1'b0;
      req_idx_q <= '0;
    end else begin
      req_v_q   <= rd_en;
      req_hit_q <= rd_win.hit;
      req_idx_q <= rd_win.index[IW-1:0];
    end
  end

  always_comb begin
    look_data = MISS_DATA;
    look_miss = 1'b1;
    if (req_hit_q && written[req_idx_q]) begin
      look_data = mem[req_idx_q];
      look_miss = 1'b0;
    end
  end

  // Data and miss only advance with a valid token, so the last stage holds
  // its previous response while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      m_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= req_v_q;
      if (req_v_q) begin
        d_q[0] <= look_data;
        m_q[0] <= look_miss;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          d_q[i] <= d_q[i-1];
          m_q[i] <= m_q[i-1];
        end
      end
    end
  end

  assign rdata  = d_q[RD_LAT-1];
  assign rvalid = v_q[RD_LAT-1];
  assign miss   = m_q[RD_LAT-1];

endmodule

// File: rtl/hht_mem_responder.sv
// Two-port read responder for HHT column and vector traffic. A request is
// sampled on a rising edge with rd_en high; its response appears RD_LAT edges
// later for one cycle with rvalid high. There is no backpressure on any port.
module hht_mem_responder #(
  parameter int          COL_DEPTH = 128,
  parameter int          V_DEPTH   = 16,
  parameter int          RD_LAT    = 2,
  parameter logic [31:0] SENTINEL  = hht_pkg::SENTINEL
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] col_base,
  input  logic [31:0] v_base,
  input  logic [31:0] csize,
  input  logic        rd1_en,
  input  logic [31:0] addr1,
  output logic [31:0] rdata1,
  output logic        rvalid1,
  output logic        miss1,
  input  logic        rd2_en,
  input  logic [31:0] addr2,
  output logic [31:0] rdata2,
  output logic        rvalid2,
  output logic        miss2,
  input  logic        WR,
  input  logic        wsel,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  output logic        wr_err,
  output logic [15:0] rd_count
);

  localparam int CIW = $clog2(COL_DEPTH);
  localparam int VIW = $clog2(V_DEPTH);
  localparam int MIW = (CIW > VIW) ? CIW : VIW;

  logic [32:0]      col_limit;
  logic [32:0]      v_limit;
  hht_pkg::region_e wr_region;
  hht_pkg::win_t    wr_win;
  logic             col_we;
  logic             v_we;
  logic             unused_widx;
  logic [16:0]      cnt_sum;

  // The active column window never exceeds the physical column storage.
  assign col_limit = (csize > 32'(COL_DEPTH)) ? 33'(COL_DEPTH) : {1'b0, csize};
  assign v_limit   = 33'(V_DEPTH);

  assign wr_region   = hht_pkg::region_e'(wsel);
  assign wr_win      = (wr_region == hht_pkg::REG_V) ?
                       hht_pkg::win_check(v_base, v_limit, waddr) :
                       hht_pkg::win_check(col_base, col_limit, waddr);
  assign col_we      = WR && (wr_region == hht_pkg::REG_COL) && wr_win.hit;
  assign v_we        = WR && (wr_region == hht_pkg::REG_V) && wr_win.hit;
  assign unused_widx = ^wr_win.index[31:MIW];

  hht_rd_port #(
    .DEPTH    (COL_DEPTH),
    .RD_LAT   (RD_LAT),
    .MISS_DATA(SENTINEL)
  ) u_col_port (
    .clk   (Clk),
    .rst   (Rst),
    .base  (col_base),
    .limit (col_limit),
    .rd_en (rd1_en),
    .addr  (addr1),
    .we    (col_we),
    .widx  (wr_win.index[CIW-1:0]),
    .wdata (wdata),
    .rdata (rdata1),
    .rvalid(rvalid1),
    .miss  (miss1)
  );

  hht_rd_port #(
    .DEPTH    (V_DEPTH),
    .RD_LAT   (RD_LAT),
    .MISS_DATA(SENTINEL)
  ) u_v_port (
    .clk   (Clk),
    .rst   (Rst),
    .base  (v_base),
    .limit (v_limit),
    .rd_en (rd2_en),
    .addr  (addr2),
    .we    (v_we),
    .widx  (wr_win.index[VIW-1:0]),
    .wdata (wdata),
    .rdata (rdata2),
    .rvalid(rvalid2),
    .miss  (miss2)
  );

  assign cnt_sum = {1'b0, rd_count} + {16'd0, rd1_en} + {16'd0, rd2_en};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_err   <= 1'b0;
      rd_count <= '0;
    end else begin
      wr_err   <= WR && !wr_win.hit;
      rd_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_hht_mem_responder.sv
// Bench for hht_mem_responder: three instances (RD_LAT 2, 1, 4) share one
// stimulus stream; responses are scored against a reference memory model.
module tb_hht_mem_responder;

  localparam logic [31:0] SENT = 32'd99999;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] col_base, v_base, csize;
  logic        rd1_en, rd2_en;
  logic [31:0] addr1, addr2;
  logic        wr, wsel;
  logic [31:0] waddr, wdata;

  logic [31:0] rdata1_w [3];
  logic [31:0] rdata2_w [3];
  logic        rvalid1_w [3];
  logic        rvalid2_w [3];
  logic        miss1_w [3];
  logic        miss2_w [3];
  logic        wr_err_w [3];
  logic [15:0] rd_count_w [3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int kill_edge = -100;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) kill_edge <= cyc + 1;
  end

  // ---------------- DUTs ----------------
  hht_mem_responder #(.RD_LAT(2)) u_dut_l2 (
    .Clk(clk), .Rst(rst), .col_base(col_base), .v_base(v_base), .csize(csize),
    .rd1_en(rd1_en), .addr1(addr1), .rdata1(rdata1_w[0]), .rvalid1(rvalid1_w[0]), .miss1(miss1_w[0]),
    .rd2_en(rd2_en), .addr2(addr2), .rdata2(rdata2_w[0]), .rvalid2(rvalid2_w[0]), .miss2(miss2_w[0]),
    .WR(wr), .wsel(wsel), .waddr(waddr), .wdata(wdata), .wr_err(wr_err_w[0]), .rd_count(rd_count_w[0]));

  hht_mem_responder #(.RD_LAT(1)) u_dut_l1 (
    .Clk(clk), .Rst(rst), .col_base(col_base), .v_base(v_base), .csize(csize),
    .rd1_en(rd1_en), .addr1(addr1), .rdata1(rdata1_w[1]), .rvalid1(rvalid1_w[1]), .miss1(miss1_w[1]),
    .rd2_en(rd2_en), .addr2(addr2), .rdata2(rdata2_w[1]), .rvalid2(rvalid2_w[1]), .miss2(miss2_w[1]),
    .WR(wr), .wsel(wsel), .waddr(waddr), .wdata(wdata), .wr_err(wr_err_w[1]), .rd_count(rd_count_w[1]));

  hht_mem_responder #(.RD_LAT(4)) u_dut_l4 (
    .Clk(clk), .Rst(rst), .col_base(col_base), .v_base(v_base), .csize(csize),
    .rd1_en(rd1_en), .addr1(addr1), .rdata1(rdata1_w[2]), .rvalid1(rvalid1_w[2]), .miss1(miss1_w[2]),
    .rd2_en(rd2_en), .addr2(addr2), .rdata2(rdata2_w[2]), .rvalid2(rvalid2_w[2]), .miss2(miss2_w[2]),
    .WR(wr), .wsel(wsel), .waddr(waddr), .wdata(wdata), .wr_err(wr_err_w[2]), .rd_count(rd_count_w[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int          s;
    logic [31:0] data;
    logic        miss;
  } exp_t;

  exp_t exp1_q[$];
  exp_t exp2_q[$];
  int   ptr1 [3];
  int   ptr2 [3];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // Reference model state.
  logic [31:0] m_col [128];
  logic [127:0] m_col_wr;
  logic [31:0] m_v [16];
  logic [15:0] m_v_wr;
  logic        exp_wr_err_d = 1'b0;
  logic        exp_wr_err = 1'b0;
  int          exp_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_wr_err <= 1'b0;
      exp_cnt    <= 0;
    end else begin
      exp_wr_err <= exp_wr_err_d;
      exp_cnt    <= (exp_cnt + int'(rd1_en) + int'(rd2_en) > 65535) ? 65535 :
                    exp_cnt + int'(rd1_en) + int'(rd2_en);
    end
  end

  function automatic logic col_hit(input logic [31:0] a, output int idx);
    logic [63:0] lim;
    logic [63:0] hi;
    lim = (csize > 32'd128) ? 64'd128 : {32'd0, csize};
    hi  = {32'd0, col_base} + lim;
    idx = int'((a - col_base) & 32'h7F);
    return (a >= col_base) && ({32'd0, a} < hi);
  endfunction

  function automatic logic v_hit(input logic [31:0] a, output int idx);
    logic [63:0] hi;
    hi  = {32'd0, v_base} + 64'd16;
    idx = int'((a - v_base) & 32'hF);
    return (a >= v_base) && ({32'd0, a} < hi);
  endfunction

  task automatic mon(input int d, input int p, input logic v, input logic [31:0] dat, input logic m);
    exp_t e;
    int   ptr;
    int   sz;
    logic have;
    int   l;
    l = lat_of(d);
    if (p == 1) begin ptr = ptr1[d]; sz = exp1_q.size(); end
    else        begin ptr = ptr2[d]; sz = exp2_q.size(); end
    have = 1'b0;
    while (ptr < sz) begin
      if (p == 1) e = exp1_q[ptr]; else e = exp2_q[ptr];
      if (e.s <= kill_edge && e.s + l >= kill_edge) ptr++;
      else break;
    end
    if (ptr < sz) begin
      if (p == 1) e = exp1_q[ptr]; else e = exp2_q[ptr];
      if (e.s + l == cyc) have = 1'b1;
    end
    if (have) begin
      chk($sformatf("rvalid%0d_lat%0d", p, l), 32'(v), 32'd1);
      chk($sformatf("rdata%0d_lat%0d", p, l), dat, e.data);
      chk($sformatf("miss%0d_lat%0d", p, l), 32'(m), 32'(e.miss));
      ptr++;
    end else if (v) begin
      chk($sformatf("spurious_rvalid%0d_lat%0d", p, l), 32'(v), 32'd0);
    end
    if (p == 1) ptr1[d] = ptr; else ptr2[d] = ptr;
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < 3; d++) begin
        mon(d, 1, rvalid1_w[d], rdata1_w[d], miss1_w[d]);
        mon(d, 2, rvalid2_w[d], rdata2_w[d], miss2_w[d]);
        chk($sformatf("wr_err_lat%0d", lat_of(d)), 32'(wr_err_w[d]), 32'(exp_wr_err));
        chk($sformatf("rd_count_lat%0d", lat_of(d)), 32'(rd_count_w[d]), 32'(exp_cnt));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r,
                      input logic r1, input logic [31:0] a1,
                      input logic r2, input logic [31:0] a2,
                      input logic w, input logic ws, input logic [31:0] wa, input logic [31:0] wd,
                      input logic ov, input logic [31:0] e1, input logic em1,
                      input logic [31:0] e2, input logic em2);
    exp_t e;
    int   idx;
    logic h;
    rst = r; rd1_en = r1; addr1 = a1; rd2_en = r2; addr2 = a2;
    wr = w; wsel = ws; waddr = wa; wdata = wd;
    exp_wr_err_d = 1'b0;
    if (r) begin
      m_col_wr = '0;
      m_v_wr   = '0;
    end else begin
      if (w) begin
        if (!ws && col_hit(wa, idx)) begin
          m_col[idx] = wd; m_col_wr[idx] = 1'b1;
        end else if (ws && v_hit(wa, idx)) begin
          m_v[idx] = wd; m_v_wr[idx] = 1'b1;
        end else begin
          exp_wr_err_d = 1'b1;
        end
      end
      if (r1) begin
        e.s = cyc + 1;
        h = col_hit(a1, idx);
        if (h && m_col_wr[idx]) begin e.data = m_col[idx]; e.miss = 1'b0; end
        else begin e.data = SENT; e.miss = 1'b1; end
        if (ov) begin e.data = e1; e.miss = em1; end
        exp1_q.push_back(e);
      end
      if (r2) begin
        e.s = cyc + 1;
        h = v_hit(a2, idx);
        if (h && m_v_wr[idx]) begin e.data = m_v[idx]; e.miss = 1'b0; end
        else begin e.data = SENT; e.miss = 1'b1; end
        if (ov) begin e.data = e2; e.miss = em2; end
        exp2_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic r1, input logic [31:0] a1, input logic r2, input logic [31:0] a2);
    step(1'b0, r1, a1, r2, a2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wr_one(input logic ws, input logic [31:0] wa, input logic [31:0] wd);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, ws, wa, wd, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_rdata1"}, rdata1_w[d], 32'd0);
      chk({tag, "_rvalid1"}, 32'(rvalid1_w[d]), 32'd0);
      chk({tag, "_miss1"}, 32'(miss1_w[d]), 32'd0);
      chk({tag, "_rdata2"}, rdata2_w[d], 32'd0);
      chk({tag, "_rvalid2"}, 32'(rvalid2_w[d]), 32'd0);
      chk({tag, "_miss2"}, 32'(miss2_w[d]), 32'd0);
      chk({tag, "_rd_count"}, 32'(rd_count_w[d]), 32'd0);
    end
  endtask

  task automatic load_regions(input logic rnd);
    logic [31:0] dv;
    for (int a = 180; a <= 281; a++) begin
      if (rnd) dv = $urandom_range(0, 1000000);
      else if (a == 180) dv = 32'd1;
      else if (a == 181) dv = 32'd13;
      else if (a == 281) dv = 32'd4;
      else dv = 32'(a * 3);
      wr_one(1'b0, 32'(a), dv);
    end
    for (int a = 2; a <= 17; a++) begin
      if (rnd) dv = $urandom_range(0, 1000000);
      else if (a == 2) dv = 32'd48;
      else if (a == 17) dv = 32'd5;
      else dv = 32'(a + 100);
      wr_one(1'b1, 32'(a), dv);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        r1;
    logic [31:0] a1;
    logic        r2;
    logic [31:0] a2;
    logic [31:0] e1;
    logic        m1;
    logic [31:0] e2;
    logic        m2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 32'd180, 1'b1, 32'd2,  32'd1,   1'b0, 32'd48,  1'b0};
    vecs[1] = '{1'b1, 32'd181, 1'b1, 32'd17, 32'd13,  1'b0, 32'd5,   1'b0};
    vecs[2] = '{1'b1, 32'd281, 1'b0, 32'd0,  32'd4,   1'b0, 32'd0,   1'b0};
    vecs[3] = '{1'b1, 32'd179, 1'b1, 32'd18, SENT,    1'b1, SENT,    1'b1};
    vecs[4] = '{1'b1, 32'd282, 1'b1, 32'd1,  SENT,    1'b1, SENT,    1'b1};
    vecs[5] = '{1'b1, 32'd250, 1'b0, 32'd0,  32'd750, 1'b0, 32'd0,   1'b0};
    vecs[6] = '{1'b0, 32'd0,   1'b1, 32'd9,  32'd0,   1'b0, 32'd109, 1'b0};

    col_base = 32'd180; v_base = 32'd2; csize = 32'd102;
    m_col_wr = '0; m_v_wr = '0;
    do_reset(2);
    chk_quiet("reset");

    // Main function: directed table.
    load_regions(1'b0);
    for (int i = 0; i < 7; i++)
      step(1'b0, vecs[i].r1, vecs[i].a1, vecs[i].r2, vecs[i].a2, 1'b0, 1'b0, 32'd0, 32'd0,
           1'b1, vecs[i].e1, vecs[i].m1, vecs[i].e2, vecs[i].m2);
    idle(6);

    // Write-first bypass, then an out-of-window vector write.
    step(1'b0, 1'b1, 32'd200, 1'b0, 32'd0, 1'b1, 1'b0, 32'd200, 32'd77,
         1'b1, 32'd77, 1'b0, 32'd0, 1'b0);
    wr_one(1'b1, 32'd18, 32'd9);
    for (int d = 0; d < 3; d++) chk("wr_err_pulse", 32'(wr_err_w[d]), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'd18, 1'b0, 1'b0, 32'd0, 32'd0,
         1'b1, 32'd0, 1'b0, SENT, 1'b1);
    for (int d = 0; d < 3; d++) chk("wr_err_clear", 32'(wr_err_w[d]), 32'd0);
    idle(6);

    // csize larger than storage is clipped to 128 entries (180..307).
    csize = 32'd1000;
    wr_one(1'b0, 32'd300, 32'd55);
    wr_one(1'b0, 32'd308, 32'd1);
    rd(1'b1, 32'd300, 1'b0, 32'd0);
    rd(1'b1, 32'd307, 1'b0, 32'd0);
    rd(1'b1, 32'd308, 1'b0, 32'd0);
    csize = 32'd102;
    rd(1'b1, 32'd300, 1'b0, 32'd0);
    idle(6);

    // Window at the top of the address space must not wrap.
    col_base = 32'hFFFF_FFF0; csize = 32'd128;
    wr_one(1'b0, 32'hFFFF_FFFF, 32'd11);
    wr_one(1'b0, 32'd0, 32'd12);
    rd(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    rd(1'b1, 32'd3, 1'b0, 32'd0);
    col_base = 32'd180; csize = 32'd102;
    idle(6);

    // Reset while reads are in flight.
    rd(1'b1, 32'd180, 1'b1, 32'd2);
    step(1'b1, 1'b1, 32'd181, 1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'd281, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(6);
    chk_quiet("midrst");
    rd(1'b1, 32'd250, 1'b1, 32'd2);
    rd(1'b1, 32'd180, 1'b0, 32'd0);
    rd(1'b1, 32'd179, 1'b0, 32'd0);
    rd(1'b1, 32'd282, 1'b0, 32'd0);
    idle(6);

    // Random dual-port traffic with interleaved writes.
    do_reset(1);
    load_regions(1'b1);
    for (int i = 0; i < 300; i++) begin
      logic w;
      logic ws;
      w  = ($urandom_range(0, 3) == 0);
      ws = $urandom_range(0, 1);
      step(1'b0, 1'b1, 32'($urandom_range(170, 290)), 1'b1, 32'($urandom_range(0, 20)),
           w, ws, ws ? 32'($urandom_range(0, 20)) : 32'($urandom_range(170, 290)),
           32'($urandom_range(0, 1000000)), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
    idle(6);
    for (int d = 0; d < 3; d++) chk("rd_count_600", 32'(rd_count_w[d]), 32'd600);

    // Saturation of the request counter.
    for (int i = 0; i < 32770; i++) rd(1'b1, 32'd180, 1'b1, 32'd2);
    idle(6);
    for (int d = 0; d < 3; d++) chk("rd_count_sat", 32'(rd_count_w[d]), 32'hFFFF);

    // Every scored response must have been seen.
    for (int d = 0; d < 3; d++) begin
      chk("drain1", 32'(ptr1[d]), 32'(exp1_q.size()));
      chk("drain2", 32'(ptr2[d]), 32'(exp2_q.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
